// File: rtl/sgpu_fill_pkg.sv
// Shared definitions for the SGPU framebuffer fill engine: register map, bit
// positions, FSM states and the byte-mask merge helper.
package sgpu_fill_pkg;

  localparam logic [4:0] REG_CTRL   = 5'h00;
  localparam logic [4:0] REG_STATUS = 5'h04;
  localparam logic [4:0] REG_DST    = 5'h08;
  localparam logic [4:0] REG_COUNT  = 5'h0C;
  localparam logic [4:0] REG_COLOR  = 5'h10;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_ABORT  = 2;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;

  typedef enum logic [1:0] {
    FILL_IDLE  = 2'd0,
    FILL_RUN   = 2'd1,
    FILL_DRAIN = 2'd2
  } fill_state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = mask[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sgpu_fill_regs.sv
// Config ICB slave for the fill engine: register file, registered responses and
// the start/abort pulses, which fire in the cycle the CTRL write is accepted.
module sgpu_fill_regs
  import sgpu_fill_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_icb_cmd_vld,
  output logic              i_icb_cmd_rdy,
  input  logic              i_icb_cmd_read,
  input  logic [ADDR_W-1:0] i_icb_cmd_addr,
  input  logic [31:0]       i_icb_cmd_wdata,
  input  logic [3:0]        i_icb_cmd_wmask,
  output logic              i_icb_rsp_vld,
  input  logic              i_icb_rsp_rdy,
  output logic [31:0]       i_icb_rsp_rdata,
  output logic              i_icb_rsp_err,
  input  logic              busy,
  input  logic              set_done,
  input  logic              set_err,
  output logic              start,
  output logic              abort,
  output logic              irq,
  output logic [31:0]       dst,
  output logic [31:0]       count,
  output logic [31:0]       color
);

  logic        rsp_vld_q, rsp_err_q, irq_en_q, done_q, err_q;
  logic [31:0] rdata_q, dst_q, count_q, color_q;

  logic [4:0]  off;
  logic        acc, wr, rd;
  logic        hit_ctrl, hit_status, hit_dst, hit_count, hit_color, mapped, locked;
  logic [31:0] rdata_d;
  logic        rsp_err_d;
  logic        unused_addr;

  assign unused_addr = ^i_icb_cmd_addr[ADDR_W-1:5];

  always_comb begin
    off        = i_icb_cmd_addr[4:0];
    acc        = i_icb_cmd_vld & ~rsp_vld_q;
    wr         = acc & ~i_icb_cmd_read;
    rd         = acc & i_icb_cmd_read;
    hit_ctrl   = (off == REG_CTRL);
    hit_status = (off == REG_STATUS);
    hit_dst    = (off == REG_DST);
    hit_count  = (off == REG_COUNT);
    hit_color  = (off == REG_COLOR);
    mapped     = hit_ctrl | hit_status | hit_dst | hit_count | hit_color;
    // Transfer parameters are frozen while a fill is in flight.
    locked     = busy & (hit_dst | hit_count | hit_color);
    start      = wr & hit_ctrl & i_icb_cmd_wmask[0] & i_icb_cmd_wdata[CTRL_START];
    abort      = wr & hit_ctrl & i_icb_cmd_wmask[0] & i_icb_cmd_wdata[CTRL_ABORT];
    rsp_err_d  = ~mapped | (wr & locked);
    rdata_d    = '0;
    if (rd) begin
      case (off)
        REG_CTRL:   rdata_d[CTRL_IRQ_EN] = irq_en_q;
        REG_STATUS: begin
          rdata_d[STAT_BUSY] = busy;
          rdata_d[STAT_DONE] = done_q;
          rdata_d[STAT_ERR]  = err_q;
        end
        REG_DST:    rdata_d = dst_q;
        REG_COUNT:  rdata_d = count_q;
        REG_COLOR:  rdata_d = color_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rdata_q   <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dst_q     <= '0;
      count_q   <= '0;
      color_q   <= '0;
    end else begin
      if (acc) begin
        rsp_vld_q <= 1'b1;
        rdata_q   <= rdata_d;
        rsp_err_q <= rsp_err_d;
      end else if (i_icb_rsp_rdy) begin
        rsp_vld_q <= 1'b0;
      end
      if (wr && hit_ctrl && i_icb_cmd_wmask[0]) begin
        irq_en_q <= i_icb_cmd_wdata[CTRL_IRQ_EN];
      end
      // Hardware set wins over a simultaneous software clear.
      if (set_done) begin
        done_q <= 1'b1;
      end else if (wr && hit_status && i_icb_cmd_wmask[0] && i_icb_cmd_wdata[STAT_DONE]) begin
        done_q <= 1'b0;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end else if (wr && hit_status && i_icb_cmd_wmask[0] && i_icb_cmd_wdata[STAT_ERR]) begin
        err_q <= 1'b0;
      end
      if (wr && !busy) begin
        if (hit_dst) begin
          dst_q <= merge_bytes(dst_q, i_icb_cmd_wdata, i_icb_cmd_wmask) & 32'hFFFF_FFF8;
        end
        if (hit_count) count_q <= merge_bytes(count_q, i_icb_cmd_wdata, i_icb_cmd_wmask);
        if (hit_color) color_q <= merge_bytes(color_q, i_icb_cmd_wdata, i_icb_cmd_wmask);
      end
    end
  end

  assign i_icb_cmd_rdy   = ~rsp_vld_q;
  assign i_icb_rsp_vld   = rsp_vld_q;
  assign i_icb_rsp_rdata = rdata_q;
  assign i_icb_rsp_err   = rsp_err_q;
  assign irq             = done_q & irq_en_q;
  assign dst             = dst_q;
  assign count           = count_q;
  assign color           = color_q;

endmodule

// File: rtl/sgpu_fill.sv
// SGPU framebuffer fill engine: streams {COLOR,COLOR} 64-bit writes over a block of
// memory through an ICB master, with a bounded number of outstanding writes.
module sgpu_fill
  import sgpu_fill_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_OUTS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_icb_cmd_vld,
  output logic              i_icb_cmd_rdy,
  input  logic              i_icb_cmd_read,
  input  logic [ADDR_W-1:0] i_icb_cmd_addr,
  input  logic [31:0]       i_icb_cmd_wdata,
  input  logic [3:0]        i_icb_cmd_wmask,
  output logic              i_icb_rsp_vld,
  input  logic              i_icb_rsp_rdy,
  output logic [31:0]       i_icb_rsp_rdata,
  output logic              i_icb_rsp_err,
  output logic              o_icb_cmd_vld,
  input  logic              o_icb_cmd_rdy,
  output logic              o_icb_cmd_read,
  output logic [ADDR_W-1:0] o_icb_cmd_addr,
  output logic [63:0]       o_icb_cmd_wdata,
  output logic [7:0]        o_icb_cmd_wmask,
  input  logic              o_icb_rsp_vld,
  output logic              o_icb_rsp_rdy,
  input  logic              o_icb_rsp_err,
  output logic              irq
);

  localparam int OutsW = $clog2(MAX_OUTS + 1);
  localparam logic [OutsW-1:0] OutsMax = OutsW'(MAX_OUTS);

  logic        start, abort, busy, set_done, set_err;
  logic [31:0] dst, count, color;

  fill_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       rem_q, color_q;
  logic              vld_q;
  logic [OutsW-1:0]  outs_q;

  logic [OutsW-1:0]  outs_d;
  logic [31:0]       rem_d;
  logic              cmd_acc, rsp_acc, issue, drain_done, zero_start;

  sgpu_fill_regs #(
    .ADDR_W (ADDR_W)
  ) u_regs (
    .clk             (clk),
    .rst             (rst),
    .i_icb_cmd_vld   (i_icb_cmd_vld),
    .i_icb_cmd_rdy   (i_icb_cmd_rdy),
    .i_icb_cmd_read  (i_icb_cmd_read),
    .i_icb_cmd_addr  (i_icb_cmd_addr),
    .i_icb_cmd_wdata (i_icb_cmd_wdata),
    .i_icb_cmd_wmask (i_icb_cmd_wmask),
    .i_icb_rsp_vld   (i_icb_rsp_vld),
    .i_icb_rsp_rdy   (i_icb_rsp_rdy),
    .i_icb_rsp_rdata (i_icb_rsp_rdata),
    .i_icb_rsp_err   (i_icb_rsp_err),
    .busy            (busy),
    .set_done        (set_done),
    .set_err         (set_err),
    .start           (start),
    .abort           (abort),
    .irq             (irq),
    .dst             (dst),
    .count           (count),
    .color           (color)
  );

  always_comb begin
    cmd_acc    = vld_q & o_icb_cmd_rdy;
    // Responses with nothing outstanding (e.g. left over from before a reset) are dropped.
    rsp_acc    = o_icb_rsp_vld & (outs_q != '0);
    outs_d     = outs_q + OutsW'(cmd_acc) - OutsW'(rsp_acc);
    rem_d      = rem_q - 32'(cmd_acc);
    issue      = (rem_d != '0) && (outs_d < OutsMax) && !abort;
    drain_done = (state_q == FILL_DRAIN) && (outs_d == '0);
    zero_start = (state_q == FILL_IDLE) && start && (count == '0);
    set_done   = drain_done | zero_start;
    set_err    = rsp_acc & o_icb_rsp_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      color_q <= '0;
      vld_q   <= 1'b0;
      outs_q  <= '0;
    end else begin
      outs_q <= outs_d;
      case (state_q)
        FILL_IDLE: begin
          if (start && count != '0) begin
            addr_q  <= ADDR_W'(dst);
            rem_q   <= count;
            color_q <= color;
            vld_q   <= 1'b1;
            state_q <= FILL_RUN;
          end
        end
        FILL_RUN: begin
          if (cmd_acc) addr_q <= addr_q + ADDR_W'(8);
          rem_q <= rem_d;
          vld_q <= issue;
          if (abort || rem_d == '0) state_q <= FILL_DRAIN;
        end
        FILL_DRAIN: begin
          vld_q <= 1'b0;
          if (outs_d == '0) state_q <= FILL_IDLE;
        end
        default: begin
          vld_q   <= 1'b0;
          state_q <= FILL_IDLE;
        end
      endcase
    end
  end

  assign busy            = (state_q != FILL_IDLE);
  assign o_icb_cmd_vld   = vld_q;
  assign o_icb_cmd_read  = 1'b0;
  assign o_icb_cmd_addr  = addr_q;
  assign o_icb_cmd_wdata = {color_q, color_q};
  assign o_icb_cmd_wmask = {8{vld_q}};
  assign o_icb_rsp_rdy   = 1'b1;

endmodule
